board_commit: RTL and testbench

Gravity-and-lock engine for the Tetris playfield. It consumes the active piece bitmap that the movement/rotation logic maintains. On each gravity tick it either tells the piece register to step down one row, or merges the piece into the settled board. After a merge it scans for and removes full rows one per pass, reports the count, and flags game over. It owns the settled-row bitmap that the movement/rotation checker and the renderer read.

---
 rtl/board_commit_if.sv | 37 +++
 rtl/board_commit.sv | 117 +++++++++++
 tb/tb_board_commit.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_commit_if.sv
// Piece/board bus between the playfield controller and the gravity-and-lock engine.
// The controller (master) drives the active piece and gravity ticks; the engine (slave) owns the settled board.
interface board_commit_if;
  logic [21:0][9:0] blocks;
  logic             drop_tick;
  logic [21:0][9:0] rows;
  logic             move_down;
  logic             lock_done;
  logic [2:0]       lines_cleared;
  logic [15:0]      lines_total;
  logic             busy;
  logic             game_over;

  modport master (
    output blocks,
    output drop_tick,
    input  rows,
    input  move_down,
    input  lock_done,
    input  lines_cleared,
    input  lines_total,
    input  busy,
    input  game_over
  );

  modport slave (
    input  blocks,
    input  drop_tick,
    output rows,
    output move_down,
    output lock_done,
    output lines_cleared,
    output lines_total,
    output busy,
    output game_over
  );
endinterface

// File: rtl/board_commit.sv
// Gravity step / lock-merge / line-clear engine over a 10x22 settled board; fall resolves 2 cycles after drop_tick, lock in 25+2n.
// drop_tick is taken only when idle and not game over; a tick arriving while busy is dropped, never queued.
module board_commit (
  input logic           Clk,
  input logic           reset_n,
  board_commit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    DOWN  = 3'd2,
    MERGE = 3'd3,
    SCAN  = 3'd4,
    SHIFT = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [21:0][9:0] rows_q, rows_d;
  logic [4:0]       r_q, r_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [2:0]       cleared_q, cleared_d;
  logic [15:0]      total_q, total_d;
  logic             game_over_q, game_over_d;
  logic             can_fall;
  logic             row_full;

  // Shifting the piece one row toward the bottom and ANDing with the board finds any collision.
  assign can_fall = (bus.blocks[21] == 10'h000) &&
                    (({bus.blocks[20:0], 10'h000} & rows_q) == '0);
  assign row_full = (rows_q[r_q] == 10'h3FF);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rows_q      <= '0;
      r_q         <= 5'd0;
      cnt_q       <= 3'd0;
      cleared_q   <= 3'd0;
      total_q     <= 16'd0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      cleared_q   <= cleared_d;
      total_q     <= total_d;
      game_over_q <= game_over_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    cleared_d   = cleared_q;
    total_d     = total_q;
    game_over_d = game_over_q;

    case (state_q)
      IDLE: begin
        if (bus.drop_tick && !game_over_q) state_d = CHECK;
      end
      CHECK: begin
        state_d = can_fall ? DOWN : MERGE;
      end
      DOWN: begin
        state_d = IDLE;
      end
      MERGE: begin
        rows_d  = rows_q | bus.blocks;
        r_d     = 5'd21;
        cnt_d   = 3'd0;
        state_d = SCAN;
      end
      SCAN: begin
        if (row_full) begin
          state_d = SHIFT;
        end else if (r_q == 5'd0) begin
          state_d = DONE;
        end else begin
          r_d = r_q - 5'd1;
        end
      end
      SHIFT: begin
        // r stays put so the row that drops into position r gets re-tested.
        for (int k = 1; k < 22; k++) begin
          if (5'(k) <= r_q) rows_d[k] = rows_q[k-1];
        end
        rows_d[0] = 10'h000;
        cnt_d     = cnt_q + 3'd1;
        total_d   = total_q + 16'd1;
        state_d   = SCAN;
      end
      DONE: begin
        cleared_d = cnt_q;
        if ((rows_q[0] | rows_q[1]) != 10'h000) game_over_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rows          = rows_q;
  assign bus.move_down     = (state_q == DOWN);
  assign bus.lock_done     = (state_q == DONE);
  assign bus.lines_cleared = cleared_q;
  assign bus.lines_total   = total_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.game_over     = game_over_q;

endmodule

// File: tb/tb_board_commit.sv
// Bench for board_commit: directed scenarios plus random piece bitmaps checked against a
// row-list reference model of gravity, merge, line removal and game over.
module tb_board_commit;
  typedef logic [21:0][9:0] board_t;
  localparam int W = 40;

  logic Clk = 1'b0;
  logic reset_n = 1'b0;

  board_commit_if bus();
  board_commit dut (.Clk(Clk), .reset_n(reset_n), .bus(bus));

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  int last_ld_t = -1;

  logic [9:0]  m_rows[22];
  logic        m_go;
  logic [2:0]  m_last;
  logic [15:0] m_total;

  task automatic model_clear();
    for (int f = 0; f < 22; f++) m_rows[f] = 10'h000;
    m_go = 1'b0;
    m_last = 3'd0;
    m_total = 16'd0;
  endtask

  function automatic board_t model_board();
    board_t x;
    for (int f = 0; f < 22; f++) x[f] = m_rows[f];
    return x;
  endfunction

  // Settled board as a list of surviving rows: full rows vanish, everything above packs down.
  task automatic model_apply(input board_t b, output bit fall, output int n);
    logic [9:0] merged[22];
    logic [9:0] kept[$];
    fall = (b[21] == 10'h000);
    for (int f = 1; f < 22; f++) if ((b[f-1] & m_rows[f]) != 10'h000) fall = 1'b0;
    n = 0;
    if (fall) return;
    for (int f = 0; f < 22; f++) merged[f] = m_rows[f] | b[f];
    for (int f = 21; f >= 0; f--) begin
      if (merged[f] == 10'h3FF) n++;
      else kept.push_back(merged[f]);
    end
    for (int f = 21; f >= 0; f--) m_rows[f] = ((21 - f) < kept.size()) ? kept[21-f] : 10'h000;
    m_last = 3'(n);
    m_total = m_total + 16'(n);
    if (m_rows[0] != 10'h000 || m_rows[1] != 10'h000) m_go = 1'b1;
  endtask

  task automatic hw_reset();
    bus.drop_tick = 1'b0;
    @(negedge Clk);
    reset_n = 1'b0;
    @(negedge Clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  // One gravity tick with optional stray tick while busy; compares every observable against the model.
  task automatic drop_and_check(input string tag, input board_t b, input bit poke);
    bit fall;
    bit ignored;
    int n;
    int poke_t;
    int md_t, ld_t, md_n, ld_n, busy_n;
    int exp_busy, exp_md_t, exp_ld_t;
    board_t exp_mid, rows_mid;
    md_t = -1; ld_t = -1; md_n = 0; ld_n = 0; busy_n = 0;
    fall = 1'b0;
    n = 0;
    rows_mid = '0;
    ignored = m_go;
    exp_mid = model_board() | b;
    if (!ignored) model_apply(b, fall, n);
    exp_busy = ignored ? 0 : (fall ? 2 : 25 + 2 * n);
    exp_md_t = (!ignored && fall) ? 1 : -1;
    exp_ld_t = (!ignored && !fall) ? 24 + 2 * n : -1;
    poke_t = -1;
    if (poke) poke_t = ignored ? 3 : (fall ? 1 : int'($urandom_range(1, 22)));

    @(negedge Clk);
    bus.blocks = b;
    bus.drop_tick = 1'b1;
    for (int t = 0; t < W; t++) begin
      @(negedge Clk);
      if (bus.move_down) begin md_n++; if (md_t < 0) md_t = t; end
      if (bus.lock_done) begin ld_n++; if (ld_t < 0) ld_t = t; end
      if (bus.busy) busy_n++;
      if (t == 2) rows_mid = bus.rows;
      bus.drop_tick = (t == poke_t);
    end
    bus.drop_tick = 1'b0;
    last_ld_t = ld_t;

    total++;
    if (busy_n !== exp_busy) begin
      bad++; $display("FAIL %s busy_cycles got=%0d want=%0d", tag, busy_n, exp_busy);
    end
    total++;
    if (md_t !== exp_md_t || md_n !== (exp_md_t < 0 ? 0 : 1)) begin
      bad++; $display("FAIL %s move_down got t=%0d n=%0d want t=%0d", tag, md_t, md_n, exp_md_t);
    end
    total++;
    if (ld_t !== exp_ld_t || ld_n !== (exp_ld_t < 0 ? 0 : 1)) begin
      bad++; $display("FAIL %s lock_done got t=%0d n=%0d want t=%0d", tag, ld_t, ld_n, exp_ld_t);
    end
    if (exp_ld_t >= 0) begin
      total++;
      if (rows_mid !== exp_mid) begin
        bad++; $display("FAIL %s merged_rows got=%h want=%h", tag, rows_mid, exp_mid);
      end
    end
    total++;
    if (bus.rows !== model_board()) begin
      bad++; $display("FAIL %s final_rows got=%h want=%h", tag, bus.rows, model_board());
    end
    total++;
    if (bus.lines_cleared !== m_last || bus.lines_total !== m_total || bus.game_over !== m_go) begin
      bad++;
      $display("FAIL %s counters got cleared=%0d total=%0d go=%b want cleared=%0d total=%0d go=%b",
               tag, bus.lines_cleared, bus.lines_total, bus.game_over, m_last, m_total, m_go);
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (bus.rows !== '0) begin bad++; $display("FAIL reset_rows got=%h want=0", bus.rows); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++;
    if (bus.move_down !== 1'b0 || bus.lock_done !== 1'b0) begin
      bad++; $display("FAIL reset_pulses got md=%b ld=%b want 0 0", bus.move_down, bus.lock_done);
    end
    total++;
    if (bus.game_over !== 1'b0) begin bad++; $display("FAIL reset_game_over got=%b want=0", bus.game_over); end
    total++;
    if (bus.lines_total !== 16'd0 || bus.lines_cleared !== 3'd0) begin
      bad++; $display("FAIL reset_counts got total=%0d cleared=%0d want 0 0", bus.lines_total, bus.lines_cleared);
    end
    @(negedge Clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_free_fall();
    board_t b;
    b = '0;
    b[10] = 10'h030;
    drop_and_check("free_fall", b, 1'b1);
  endtask

  task automatic test_floor_lock();
    board_t b;
    b = '0;
    b[21] = 10'h3C0;
    drop_and_check("floor_lock", b, 1'b1);
    total++;
    if (bus.rows[21] !== 10'h3C0 || last_ld_t !== 24 || bus.lines_cleared !== 3'd0 || bus.game_over !== 1'b0) begin
      bad++;
      $display("FAIL floor_lock_fixed got row21=%h ld_t=%0d cleared=%0d go=%b want 3c0 24 0 0",
               bus.rows[21], last_ld_t, bus.lines_cleared, bus.game_over);
    end
  endtask

  task automatic test_single_clear();
    board_t b;
    b = '0; b[21] = 10'h030;
    drop_and_check("build_a", b, 1'b0);
    b = '0; b[20] = 10'h200;
    drop_and_check("build_b", b, 1'b0);
    total++;
    if (bus.rows[21] !== 10'h3F0 || bus.rows[20] !== 10'h200) begin
      bad++; $display("FAIL single_setup got r21=%h r20=%h want 3f0 200", bus.rows[21], bus.rows[20]);
    end
    b = '0; b[21] = 10'h00F;
    drop_and_check("single_clear", b, 1'b1);
    total++;
    if (bus.rows[21] !== 10'h200 || bus.rows[20] !== 10'h000 || bus.lines_cleared !== 3'd1 ||
        bus.lines_total !== 16'd1 || last_ld_t !== 26) begin
      bad++;
      $display("FAIL single_fixed got r21=%h r20=%h cleared=%0d total=%0d ld_t=%0d want 200 0 1 1 26",
               bus.rows[21], bus.rows[20], bus.lines_cleared, bus.lines_total, last_ld_t);
    end
  endtask

  task automatic test_reset_mid_scan();
    board_t b;
    b = '0; b[21] = 10'h001;
    @(negedge Clk);
    bus.blocks = b;
    bus.drop_tick = 1'b1;
    @(negedge Clk);
    bus.drop_tick = 1'b0;
    repeat (8) @(negedge Clk);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL midscan_busy got=%b want=1", bus.busy); end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (bus.rows !== '0 || bus.busy !== 1'b0 || bus.move_down !== 1'b0 || bus.lock_done !== 1'b0) begin
      bad++; $display("FAIL midscan_reset_state got rows=%h busy=%b", bus.rows, bus.busy);
    end
    total++;
    if (bus.lines_total !== 16'd0 || bus.lines_cleared !== 3'd0 || bus.game_over !== 1'b0) begin
      bad++; $display("FAIL midscan_reset_counts got total=%0d cleared=%0d go=%b want 0 0 0",
                      bus.lines_total, bus.lines_cleared, bus.game_over);
    end
    @(negedge Clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_four_clear();
    board_t b;
    b = '0;
    for (int f = 18; f < 22; f++) b[f] = 10'h3FE;
    drop_and_check("four_build", b, 1'b0);
    b = '0;
    for (int f = 18; f < 22; f++) b[f] = 10'h001;
    drop_and_check("four_clear", b, 1'b1);
    total++;
    if (bus.rows !== '0 || bus.lines_cleared !== 3'd4 || bus.lines_total !== 16'd4 || last_ld_t !== 32) begin
      bad++; $display("FAIL four_fixed got cleared=%0d total=%0d ld_t=%0d want 4 4 32",
                      bus.lines_cleared, bus.lines_total, last_ld_t);
    end
  endtask

  task automatic test_game_over();
    board_t b;
    b = '0;
    for (int f = 1; f < 22; f++) b[f] = 10'h018;
    drop_and_check("go_lock", b, 1'b1);
    total++;
    if (bus.game_over !== 1'b1 || bus.rows[1] !== 10'h018) begin
      bad++; $display("FAIL go_set got go=%b r1=%h want 1 018", bus.game_over, bus.rows[1]);
    end
    for (int i = 0; i < 3; i++) begin
      b = '0;
      b[21] = 10'($urandom);
      b[5] = 10'($urandom);
      drop_and_check("go_ignored", b, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    board_t b;
    bit fall;
    int n;
    int wait_n;
    hw_reset();
    b = '0; b[10] = 10'h030;
    @(negedge Clk);
    bus.blocks = b;
    bus.drop_tick = 1'b1;
    @(negedge Clk);
    bus.drop_tick = 1'b0;
    @(negedge Clk);
    total++;
    if (bus.move_down !== 1'b1) begin bad++; $display("FAIL b2b_fall_md got=%b want=1", bus.move_down); end
    @(negedge Clk);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_fall_idle got=%b want=0", bus.busy); end
    bus.drop_tick = 1'b1;
    @(negedge Clk);
    bus.drop_tick = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_after_fall_busy got=%b want=1", bus.busy); end
    @(negedge Clk);
    total++;
    if (bus.move_down !== 1'b1) begin bad++; $display("FAIL b2b_second_md got=%b want=1", bus.move_down); end
    @(negedge Clk);

    b = '0; b[21] = 10'h001;
    model_apply(b, fall, n);
    @(negedge Clk);
    bus.blocks = b;
    bus.drop_tick = 1'b1;
    for (int t = 0; t <= 26; t++) begin
      @(negedge Clk);
      if (t == 24) begin
        total++;
        if (bus.lock_done !== 1'b1) begin bad++; $display("FAIL b2b_lock_done got=%b want=1", bus.lock_done); end
      end
      if (t == 25) begin
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_lock_idle got=%b want=0", bus.busy); end
      end
      if (t == 26) begin
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_after_lock_busy got=%b want=1", bus.busy); end
      end
      bus.drop_tick = (t == 25);
    end
    bus.drop_tick = 1'b0;
    model_apply(b, fall, n);
    wait_n = 0;
    while (bus.busy && wait_n < W) begin
      @(negedge Clk);
      wait_n++;
    end
    total++;
    if (bus.busy !== 1'b0 || bus.rows !== model_board()) begin
      bad++; $display("FAIL b2b_final got busy=%b rows=%h want 0 %h", bus.busy, bus.rows, model_board());
    end
  endtask

  task automatic test_random();
    board_t b;
    int s, h;
    hw_reset();
    for (int i = 0; i < 100; i++) begin
      b = '0;
      h = $urandom_range(1, 4);
      s = $urandom_range(2, 22 - h);
      if ($urandom_range(0, 2) == 0) s = 22 - h;
      for (int f = s; f < s + h; f++) begin
        case ($urandom_range(0, 3))
          0:       b[f] = 10'h000;
          1:       b[f] = 10'($urandom);
          default: b[f] = ~m_rows[f];
        endcase
      end
      drop_and_check("random", b, $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    bus.blocks = '0;
    bus.drop_tick = 1'b0;
    test_reset();
    test_free_fall();
    test_floor_lock();
    test_single_clear();
    test_reset_mid_scan();
    test_four_clear();
    test_game_over();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
